// File: rtl/mvma_pkg.sv
// Shared types and arithmetic helpers for the matrix-vector multiply-add engine.
// Holds the accumulator and activation types, control state encoding and the requantisation function.
package mvma_pkg;

  typedef logic signed [15:0] acc_t;
  typedef logic signed [7:0]  act_t;

  localparam act_t ACT_MAX = 8'sh7F;
  localparam act_t ACT_MIN = 8'sh80;

  typedef struct packed {
    act_t act;
    logic sat;
  } requant_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FILL  = 2'd1,
    ST_FULL  = 2'd2
  } ctrl_state_t;

  // A wrapped accumulator carries the wrong sign, so overflow saturates toward the opposite rail.
  function automatic requant_t requant(input acc_t acc, input logic ovf, input int unsigned shift);
    logic signed [16:0] rnd;
    logic signed [16:0] wide;
    requant_t           res;
    res.act = 8'sh00;
    res.sat = 1'b0;
    rnd     = 17'sd0;
    wide    = 17'sd0;
    if (ovf) begin
      res.act = acc[15] ? ACT_MAX : ACT_MIN;
      res.sat = 1'b1;
    end else begin
      if (shift != 0) begin
        rnd = 17'sd1 <<< (shift - 1);
      end else begin
        rnd = 17'sd0;
      end
      wide = ($signed({acc[15], acc}) + rnd) >>> shift;
      if (wide > 17'sd127) begin
        res.act = ACT_MAX;
        res.sat = 1'b1;
      end else if (wide < -17'sd128) begin
        res.act = ACT_MIN;
        res.sat = 1'b1;
      end else begin
        res.act = $signed(wide[7:0]);
        res.sat = 1'b0;
      end
    end
    return res;
  endfunction

  function automatic logic parity8(input logic [7:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with combinational head read, full/empty flags and an occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (count_r == CW'(DEPTH));
  assign empty     = (count_r == CW'(0));
  assign count     = count_r;
  assign dout      = mem_r[rd_ptr_r];
  assign do_push_s = push && (!full || pop);
  assign do_pop_s  = pop && !empty;

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      count_r  <= CW'(0);
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/act_requant_stage.sv
// Requantises 16-bit matrix-vector results to 8-bit activations and streams them through a FIFO.
// Define RELU_EN to clip negative activations to zero.
module act_requant_stage
  import mvma_pkg::*;
#(
  parameter int unsigned SHIFT   = 2,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned VEC_LEN = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic signed [15:0] data_in,
  input  logic               overflow_in,
  output logic               m_valid,
  input  logic               m_ready,
  output logic signed [7:0]  data_out,
  output logic               m_last,
  output logic [7:0]         sat_count
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned OW = CW + 1;
  localparam int unsigned EW = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;

  requant_t    rq_s;
  act_t        act_s;
  logic        accept_s;
  logic        pop_s;
  logic        push_s;
  logic        pipe_v_r;
  act_t        pipe_d_r;
  logic        pipe_sat_r;
  logic [8:0]  fifo_din_s;
  logic [8:0]  head_s;
  logic        head_ok_s;
  logic        fifo_full_s;
  logic        fifo_empty_s;
  logic [CW-1:0] fifo_count_s;
  logic [OW-1:0] occ_s;
  logic [OW-1:0] occ_nxt_s;
  logic [EW-1:0] elem_cnt_r;
  logic [7:0]    sat_count_r;
  ctrl_state_t   state_r;
  ctrl_state_t   state_nxt_s;

  assign rq_s     = requant(data_in, overflow_in, SHIFT);
  assign s_ready  = !reset && (state_r != ST_FULL);
  assign accept_s = s_valid && s_ready;
  assign m_valid  = !fifo_empty_s;
  assign pop_s    = m_valid && m_ready;
  assign push_s   = pipe_v_r && (!fifo_full_s || pop_s);
  assign occ_s    = OW'(fifo_count_s) + OW'(pipe_v_r);

  // Optional ReLU on the saturated/clamped value; it never counts as saturation.
  always_comb begin
    act_s = rq_s.act;
`ifdef RELU_EN
    if (rq_s.act[7]) begin
      act_s = 8'sh00;
    end else begin
      act_s = rq_s.act;
    end
`else
    act_s = rq_s.act;
`endif
  end

  // Single pipe register between the input handshake and the FIFO.
  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_v_r   <= 1'b0;
      pipe_d_r   <= 8'sh00;
      pipe_sat_r <= 1'b0;
    end else begin
      pipe_v_r <= accept_s;
      if (accept_s) begin
        pipe_d_r   <= act_s;
        pipe_sat_r <= rq_s.sat;
      end
    end
  end

  // Spare FIFO bit carries even parity; a corrupted head is suppressed to zero.
  assign fifo_din_s = {parity8(pipe_d_r), pipe_d_r};
  assign head_ok_s  = (head_s[8] == parity8(head_s[7:0]));
  assign data_out   = (m_valid && head_ok_s) ? $signed(head_s[7:0]) : 8'sh00;
  assign m_last     = m_valid && (elem_cnt_r == EW'(VEC_LEN - 1));
  assign sat_count  = sat_count_r;

  sync_fifo #(
    .WIDTH (9),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_s),
    .din   (fifo_din_s),
    .pop   (pop_s),
    .dout  (head_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_count_s)
  );

  // Position of the FIFO head within its output vector.
  always_ff @(posedge clk) begin
    if (reset) begin
      elem_cnt_r <= EW'(0);
    end else if (pop_s) begin
      if (elem_cnt_r == EW'(VEC_LEN - 1)) begin
        elem_cnt_r <= EW'(0);
      end else begin
        elem_cnt_r <= elem_cnt_r + EW'(1);
      end
    end
  end

  // Saturation event counter, sticky at its maximum.
  always_ff @(posedge clk) begin
    if (reset) begin
      sat_count_r <= 8'd0;
    end else if (push_s && pipe_sat_r && (sat_count_r != 8'hFF)) begin
      sat_count_r <= sat_count_r + 8'd1;
    end
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_EMPTY;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Occupancy (FIFO plus pipe) only moves on accept and pop; pipe-to-FIFO transfer is neutral.
  always_comb begin
    state_nxt_s = state_r;
    occ_nxt_s   = occ_s + OW'(accept_s) - OW'(pop_s);
    case (state_r)
      ST_EMPTY: begin
        if (accept_s) begin
          state_nxt_s = ST_FILL;
        end else begin
          state_nxt_s = ST_EMPTY;
        end
      end
      ST_FILL: begin
        if (occ_nxt_s == OW'(0)) begin
          state_nxt_s = ST_EMPTY;
        end else if (occ_nxt_s == OW'(DEPTH)) begin
          state_nxt_s = ST_FULL;
        end else begin
          state_nxt_s = ST_FILL;
        end
      end
      ST_FULL: begin
        if (pop_s) begin
          state_nxt_s = ST_FILL;
        end else begin
          state_nxt_s = ST_FULL;
        end
      end
      default: state_nxt_s = ST_EMPTY;
    endcase
  end

endmodule

// File: tb/tb_act_requant_stage.sv
// Scoreboard bench for act_requant_stage: expected activations are queued at accept and compared at the head.
module tb_act_requant_stage;

  localparam int SHIFT   = 2;
  localparam int DEPTH   = 4;
  localparam int VEC_LEN = 4;

  logic               clk = 1'b0;
  logic               reset;
  logic               s_valid;
  logic               s_ready;
  logic signed [15:0] data_in;
  logic               overflow_in;
  logic               m_valid;
  logic               m_ready = 1'b0;
  logic signed [7:0]  data_out;
  logic               m_last;
  logic [7:0]         sat_count;

  int errors = 0;
  int checks = 0;
  logic signed [7:0] exp_q[$];
  int pop_cnt   = 0;
  int sat_exp   = 0;
  int last_seen = 0;
  logic rnd_ready_en = 1'b0;
  logic m_ready_cmd  = 1'b0;

  always #5 clk = ~clk;

  act_requant_stage #(
    .SHIFT   (SHIFT),
    .DEPTH   (DEPTH),
    .VEC_LEN (VEC_LEN)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .data_in     (data_in),
    .overflow_in (overflow_in),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .data_out    (data_out),
    .m_last      (m_last),
    .sat_count   (sat_count)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Floor-division reference for the rounding shift and clamp.
  function automatic void model(input logic signed [15:0] d, input logic o,
                                output logic signed [7:0] a, output logic s);
    int v, dv, q;
    dv = 1 << SHIFT;
    s  = 1'b0;
    if (o) begin
      q = (d < 0) ? 127 : -128;
      s = 1'b1;
    end else begin
      v = int'(d) + ((SHIFT > 0) ? (dv / 2) : 0);
      q = v / dv;
      if ((v % dv) != 0 && v < 0) q = q - 1;
      if (q > 127) begin q = 127; s = 1'b1; end
      else if (q < -128) begin q = -128; s = 1'b1; end
    end
`ifdef RELU_EN
    if (q < 0) q = 0;
`endif
    a = 8'(q);
  endfunction

  always @(posedge clk) begin
    #2;
    if (rnd_ready_en) m_ready = ($urandom_range(0, 2) != 0);
    else              m_ready = m_ready_cmd;
  end

  always @(negedge clk) begin : mon
    logic signed [7:0] e;
    logic s;
    if (reset) begin
      exp_q.delete();
      pop_cnt = 0;
      sat_exp = 0;
    end else begin
      if (m_valid) begin
        if (exp_q.size() == 0) begin
          check_eq("spurious_valid", 1, 0);
        end else begin
          check_eq("head_data", data_out, exp_q[0]);
          check_eq("head_last", m_last, (pop_cnt % VEC_LEN) == (VEC_LEN - 1));
          if (m_ready) begin
            void'(exp_q.pop_front());
            if (m_last) last_seen++;
            pop_cnt++;
          end
        end
      end else begin
        check_eq("empty_data", data_out, 0);
        check_eq("empty_last", m_last, 0);
      end
      if (s_valid && s_ready) begin
        model(data_in, overflow_in, e, s);
        exp_q.push_back(e);
        if (s && sat_exp < 255) sat_exp++;
      end
    end
  end

  task automatic send(input int d, input logic o);
    logic acc;
    int n;
    n = 0;
    acc = 1'b0;
    s_valid = 1'b1;
    data_in = 16'(d);
    overflow_in = o;
    while (!acc && n < 500) begin
      @(negedge clk);
      acc = s_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) check_eq("send_timeout", 0, 1);
    s_valid = 1'b0;
    overflow_in = 1'b0;
  endtask

  // Requires an idle pipe and m_ready=1.
  task automatic send_lat(input int d, input logic o, input int exp);
    send(d, o);
    check_eq("lat_early", m_valid, 0);
    @(posedge clk);
    #1;
    check_eq("lat_valid", m_valid, 1);
    check_eq("lat_data", data_out, exp);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || m_valid) && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq("drain_done", (n < 3000), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acc, k, last0;
    logic a;
    reset = 1'b1;
    s_valid = 1'b0;
    data_in = 16'sd0;
    overflow_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_s_ready", s_ready, 0);
    check_eq("rst_m_valid", m_valid, 0);
    check_eq("rst_data", data_out, 0);
    check_eq("rst_last", m_last, 0);
    check_eq("rst_sat", sat_count, 0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_eq("post_rst_s_ready", s_ready, 1);
    m_ready_cmd = 1'b1;
    @(posedge clk);
    #1;

    // Basic rounding and clamp
    send_lat(10, 1'b0, 3);
    send_lat(1000, 1'b0, 127);
`ifdef RELU_EN
    send_lat(-7, 1'b0, 0);
`else
    send_lat(-7, 1'b0, -2);
`endif
    drain();
    check_eq("sat_t1", sat_count, 1);

    // Overflow saturation
    send_lat(32'h8000, 1'b1, 127);
`ifdef RELU_EN
    send_lat(32'h7FF0, 1'b1, 0);
`else
    send_lat(32'h7FF0, 1'b1, -128);
`endif
    drain();
    check_eq("sat_t2", sat_count, 3);
    check_eq("sat_t2_model", sat_count, sat_exp);

    // Backpressure: only DEPTH elements fit
    m_ready_cmd = 1'b0;
    @(posedge clk);
    #1;
    acc = 0;
    k = 0;
    s_valid = 1'b1;
    data_in = 16'(40 * k - 90);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      a = s_ready;
      @(posedge clk);
      #1;
      if (a) begin
        acc++;
        if (acc == 4) check_eq("full_after_4th", s_ready, 0);
        k++;
        data_in = 16'(40 * k - 90);
      end
    end
    check_eq("accepted_count", acc, 4);
    check_eq("full_hold", s_ready, 0);
    s_valid = 1'b0;
    m_ready_cmd = 1'b1;
    check_eq("full_before_pop", s_ready, 0);
    @(posedge clk);
    #1;
    check_eq("ready_after_pop", s_ready, 1);
    drain();

    // Vector framing from a clean element counter
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    last_seen = 0;
    send(5, 1'b0);
    check_eq("t4_lat_early", m_valid, 0);
    send(9, 1'b0);
    check_eq("t4_lat_valid", m_valid, 1);
    for (int i = 0; i < 6; i++) send(i * 300 - 700, 1'b0);
    drain();
    check_eq("t4_last_count", last_seen, 2);

    // Random traffic
    rnd_ready_en = 1'b1;
    for (int i = 0; i < 200; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      if ($urandom_range(0, 1) == 0) send(int'($urandom_range(0, 65535)), ($urandom_range(0, 7) == 0));
      else                           send(int'($urandom_range(0, 1019)) - 510, ($urandom_range(0, 7) == 0));
    end
    drain();
    rnd_ready_en = 1'b0;
    m_ready_cmd = 1'b1;
    check_eq("t5_sat", sat_count, sat_exp);

    // Reset with data in flight
    m_ready_cmd = 1'b0;
    @(posedge clk);
    #1;
    send(1000, 1'b0);
    send(20, 1'b0);
    send(-30, 1'b0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    check_eq("t6_pre_valid", m_valid, 1);
    check_eq("t6_pre_sat", sat_count, sat_exp);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_eq("t6_valid", m_valid, 0);
    check_eq("t6_sat", sat_count, 0);
    check_eq("t6_last", m_last, 0);
    check_eq("t6_data", data_out, 0);
    check_eq("t6_s_ready", s_ready, 0);
    reset = 1'b0;
    m_ready_cmd = 1'b1;
    @(posedge clk);
    #1;
    last0 = last_seen;
    for (int i = 0; i < 4; i++) send(i * 50 + 3, 1'b0);
    drain();
    check_eq("t6_last_count", last_seen - last0, 1);
    check_eq("final_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
